// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation slice.
//
// Contents:
//   RSA_WIDTH      default operand width in bits
//   MODMUL_CYCLES  cycles taken by one modular multiply at the default width
//   modmul_cycles  same figure for any width
//   state_t        sequencing FSM states of rsa_modexp_core
//   mm_phase_t     internal phases of the rsa_modmul sub-module
//
// Configuration macro used by this slice: MODEXP_LEADING_ZERO_SKIP_EN
// (read in rsa_modexp_core only).

package rsa_pkg;

   localparam int RSA_WIDTH     = 512;
   localparam int MODMUL_CYCLES = RSA_WIDTH + 2;

   // One multiply is one issue cycle, w shift-add iterations and one writeback.
   function automatic int modmul_cycles(input int w);
      return w + 2;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_SQUARE,
      ST_MULT,
      ST_FINISH
   } state_t;

   typedef enum logic [1:0] {
      MM_IDLE,
      MM_RUN,
      MM_WB
   } mm_phase_t;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: product = a*b mod n.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, aborts any operation
//   start    in   issue pulse, sampled only while idle; a, b, n latched here
//   a, b, n  in   WIDTH-bit operands, caller guarantees a < n and b < n
//   product  out  WIDTH-bit result, valid while done is high
//   done     out  one-cycle pulse exactly WIDTH+1 cycles after the issue cycle
//
// The multiplier a is scanned MSB first. Each iteration computes
// R = 2R + a_j*b and then subtracts n at most twice, keeping R < n.
// R is WIDTH+2 bits wide because 2R + b can reach almost 3n.

module rsa_modmul
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] product,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mm_phase_t        phase;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH+1:0] r;
   logic [WIDTH+1:0] r_next;
   logic [WIDTH+1:0] n_ext;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] sum_red;
   logic [CNT_W-1:0] cnt;

   // One shift-add step followed by two conditional subtractions.
   // Because R < n and b < n on entry, sum < 3n, so two subtractions
   // always bring it back below n.
   always_comb begin
      n_ext   = {2'b00, n_r};
      sum     = (r << 1) + (a_sh[WIDTH-1] ? {2'b00, b_r} : '0);
      sum_red = (sum >= n_ext) ? (sum - n_ext) : sum;
      r_next  = (sum_red >= n_ext) ? (sum_red - n_ext) : sum_red;
   end

   // Phase sequencing: issue latches operands, RUN does WIDTH steps,
   // WB presents the product for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= MM_IDLE;
         a_sh  <= '0;
         b_r   <= '0;
         n_r   <= '0;
         r     <= '0;
         cnt   <= '0;
      end else begin
         case (phase)
            MM_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_r   <= b;
                  n_r   <= n;
                  r     <= '0;
                  cnt   <= CNT_W'(WIDTH - 1);
                  phase <= MM_RUN;
               end
            end
            MM_RUN: begin
               r    <= r_next;
               a_sh <= a_sh << 1;
               if (cnt == '0) begin
                  phase <= MM_WB;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            MM_WB: begin
               phase <= MM_IDLE;
            end
            default: begin
               phase <= MM_IDLE;
            end
         endcase
      end
   end

   assign done    = (phase == MM_WB);
   assign product = r[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply engine: result = base^exponent mod modulus.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, aborts without a done pulse
//   start     in   request pulse, operands sampled while idle
//   base      in   WIDTH-bit base, must be < modulus
//   exponent  in   WIDTH-bit exponent
//   modulus   in   WIDTH-bit modulus, must be non-zero
//   result    out  WIDTH-bit result, held until the next completion
//   done      out  one-cycle pulse when result/err are valid
//   busy      out  high from the cycle after an accepted start through done
//   err       out  illegal operands flag, set with done, cleared by next start
//
// Configuration macro: MODEXP_LEADING_ZERO_SKIP_EN
//   defined   : scanning starts at the exponent's most significant set bit,
//               a zero exponent finishes straight from CHECK
//   undefined : all WIDTH exponent bits are scanned, so latency depends only
//               on the exponent's popcount
//
// All modular products come from one shared rsa_modmul instance.

module rsa_modexp_core
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] base_r;
   logic [WIDTH-1:0] exp_r;
   logic [WIDTH-1:0] mod_r;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] result_r;
   logic             err_r;
   logic [IDX_W-1:0] idx;
   logic             issued;
   logic             mm_start;
   logic             mm_done;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_product;
   logic             operands_bad;
   logic [WIDTH-1:0] acc_init;
   logic             bit_set;
   logic             last_bit;

   assign operands_bad = (mod_r == '0) || (base_r >= mod_r);
   assign acc_init     = (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
   assign bit_set      = exp_r[idx];
   assign last_bit     = (idx == '0);

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
   logic [IDX_W-1:0] msb_idx;
   logic             exp_zero;

   // Highest set bit of the exponent; only meaningful when it is non-zero.
   always_comb begin
      msb_idx = '0;
      for (int k = 0; k < WIDTH; k++) begin
         if (exp_r[k]) begin
            msb_idx = IDX_W'(k);
         end
      end
   end

   assign exp_zero = (exp_r == '0);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The "NEXT" step costs no cycle: the bit-index
   // decision is taken in the same cycle the multiplier reports done.
   // A multiply is issued on the first cycle of SQUARE/MULT only.
   always_comb begin
      state_next = state;
      mm_start   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (operands_bad) begin
               state_next = ST_FINISH;
            end else begin
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
               state_next = exp_zero ? ST_FINISH : ST_SQUARE;
`else
               state_next = ST_SQUARE;
`endif
            end
         end
         ST_SQUARE: begin
            mm_start = !issued;
            if (mm_done) begin
               if (bit_set) begin
                  state_next = ST_MULT;
               end else if (last_bit) begin
                  state_next = ST_FINISH;
               end else begin
                  state_next = ST_SQUARE;
               end
            end
         end
         ST_MULT: begin
            mm_start = !issued;
            if (mm_done) begin
               state_next = last_bit ? ST_FINISH : ST_SQUARE;
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Tracks that the current SQUARE/MULT already issued its multiply, so
   // the multiplier sees exactly one start per state visit.
   always_ff @(posedge clk) begin
      if (rst) begin
         issued <= 1'b0;
      end else if (mm_start) begin
         issued <= 1'b1;
      end else if (mm_done) begin
         issued <= 1'b0;
      end
   end

   // Operand registers, accumulator, bit index and the held outputs.
   // result is written on the edge that enters FINISH so it is valid
   // in the same cycle as done.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_r   <= '0;
         exp_r    <= '0;
         mod_r    <= '0;
         acc      <= '0;
         idx      <= '0;
         result_r <= '0;
         err_r    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_r <= base;
                  exp_r  <= exponent;
                  mod_r  <= modulus;
                  idx    <= IDX_W'(WIDTH - 1);
                  err_r  <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (operands_bad) begin
                  err_r    <= 1'b1;
                  result_r <= '0;
               end else begin
                  acc <= acc_init;
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
                  idx <= msb_idx;
                  if (exp_zero) begin
                     result_r <= acc_init;
                  end
`endif
               end
            end
            ST_SQUARE: begin
               if (mm_done) begin
                  acc <= mm_product;
                  if (!bit_set) begin
                     if (last_bit) begin
                        result_r <= mm_product;
                     end else begin
                        idx <= idx - 1'b1;
                     end
                  end
               end
            end
            ST_MULT: begin
               if (mm_done) begin
                  acc <= mm_product;
                  if (last_bit) begin
                     result_r <= mm_product;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Squaring uses acc for both operands; multiplying brings in the base.
   assign mm_b = (state == ST_MULT) ? base_r : acc;

   rsa_modmul #(
      .WIDTH (WIDTH)
   ) u_modmul (
      .clk     (clk),
      .rst     (rst),
      .start   (mm_start),
      .a       (acc),
      .b       (mm_b),
      .n       (mod_r),
      .product (mm_product),
      .done    (mm_done)
   );

   assign result = result_r;
   assign err    = err_r;
   assign done   = (state == ST_FINISH);
   assign busy   = (state != ST_IDLE);

endmodule
